// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end that sequences CS/WE/OE strobes for ramchip.
// Optional macro SRAM_CTRL_RANGE_CHK_EN rejects out-of-range addresses.
module sram_ctrl #(
  parameter int ADDRESS_SIZE = 64,
  parameter int WORD_SIZE = 32,
  parameter int WAIT_CYCLES = 1,
  localparam int AW = $clog2(ADDRESS_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [AW-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_cs_n,
  output logic                 mem_we_n,
  output logic                 mem_oe_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  state_t     state;
  logic       wr;
  logic       err_pend;
  logic [3:0] cnt;
  logic       bad_addr;

`ifdef SRAM_CTRL_RANGE_CHK_EN
  assign bad_addr = {1'b0, req_addr} >= (AW+1)'(ADDRESS_SIZE);
`else
  assign bad_addr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr        <= 1'b0;
      err_pend  <= 1'b0;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr        <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (bad_addr) begin
              err_pend <= 1'b1;
              state    <= RESP;
            end else begin
              mem_cs_n <= 1'b0;
              state    <= SETUP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          cnt      <= 4'(WAIT_CYCLES);
          mem_we_n <= !wr;
          mem_oe_n <= wr;
          state    <= STROBE;
        end
        STROBE: begin
          // sample read data while OE is still low
          if (cnt == 4'd0) begin
            if (!wr) rsp_rdata <= mem_rdata;
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          mem_cs_n  <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (err_pend) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            err_pend  <= 1'b0;
          end
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: vector table plus scoreboard bench for sram_ctrl.
// Main DUT uses WAIT_CYCLES=1, ADDRESS_SIZE=48; a second uses WAIT_CYCLES=0.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int W  = 1;
  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_cs_n, mem_we_n, mem_oe_n;

  logic          req_valid0, req_ready0, req_we0;
  logic [AW-1:0] req_addr0;
  logic [DW-1:0] req_wdata0;
  logic          rsp_valid0, rsp_err0;
  logic [DW-1:0] rsp_rdata0, mem_wdata0, mem_rdata0;
  logic [AW-1:0] mem_addr0;
  logic          mem_cs_n0, mem_we_n0, mem_oe_n0;

  sram_ctrl #(.ADDRESS_SIZE(48), .WORD_SIZE(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n)
  );

  sram_ctrl #(.ADDRESS_SIZE(64), .WORD_SIZE(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .mem_cs_n(mem_cs_n0), .mem_we_n(mem_we_n0), .mem_oe_n(mem_oe_n0)
  );

  // ramchip models: async read, write while CS and WE are low
  logic [DW-1:0] chip  [64];
  logic [DW-1:0] chip0 [64];
  logic preload;
  assign mem_rdata  = chip[mem_addr];
  assign mem_rdata0 = chip0[mem_addr0];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        chip[i]  <= '0;
        chip0[i] <= '0;
      end
      chip0[63] <= 32'h1234_5678;
    end else begin
      if (!mem_cs_n && !mem_we_n) chip[mem_addr] <= mem_wdata;
      if (!mem_cs_n0 && !mem_we_n0) chip0[mem_addr0] <= mem_wdata0;
    end
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } rec_t;

  typedef struct {
    logic        we;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  rec_t sb[$];
  rec_t got[$];
  int cyc = 0;
  int cs_lo = 0, we_lo = 0, oe_lo = 0, oe_lo0 = 0, we_lo0 = 0;
  int strobe_bad = 0, rsp_cnt = 0;
  int checks = 0, failures = 0;
  logic [31:0] shadow [64];
  logic [31:0] last_rd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!mem_cs_n) cs_lo++;
    if (!mem_we_n) we_lo++;
    if (!mem_oe_n) oe_lo++;
    if (!mem_we_n0) we_lo0++;
    if (!mem_oe_n0) oe_lo0++;
    if (!mem_we_n && !mem_oe_n) strobe_bad++;
    if ((!mem_we_n || !mem_oe_n) && mem_cs_n) strobe_bad++;
    if (!mem_we_n0 && !mem_oe_n0) strobe_bad++;
    if ((!mem_we_n0 || !mem_oe_n0) && mem_cs_n0) strobe_bad++;
    if (rsp_valid) begin
      rsp_cnt++;
      got.push_back('{rd: rsp_rdata, err: rsp_err, cyc: cyc});
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(input string nm);
    rec_t x, r;
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (got.size() > 0) ok = 1;
    end
    check({nm, "_rsp_seen"}, 32'(ok), 32'd1);
    if (!ok || sb.size() == 0) return;
    x = sb.pop_front();
    r = got.pop_front();
    check({nm, "_rdata"}, r.rd, x.rd);
    check({nm, "_err"}, 32'(r.err), 32'(x.err));
    check({nm, "_latency"}, 32'(r.cyc), 32'(x.cyc));
  endtask

  task automatic accept(output bit ok, output int e0);
    ok = 0;
    e0 = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) begin
        ok = 1;
        e0 = cyc + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_req(input logic we, input logic [5:0] a,
                         input logic [31:0] wd, input logic [31:0] erd,
                         input logic eerr, input string nm);
    int c0, w0, o0, e0;
    bit ok;
    c0 = cs_lo;
    w0 = we_lo;
    o0 = oe_lo;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    accept(ok, e0);
    req_valid = 1'b0;
    check({nm, "_accept"}, 32'(ok), 32'd1);
    if (!ok) return;
    sb.push_back('{rd: erd, err: eerr, cyc: e0 + (eerr ? 1 : W + 3)});
    wait_rsp(nm);
    check({nm, "_cs_cycles"}, 32'(cs_lo - c0), eerr ? 32'd0 : 32'(W + 3));
    check({nm, "_we_cycles"}, 32'(we_lo - w0),
          (we && !eerr) ? 32'(W + 1) : 32'd0);
    check({nm, "_oe_cycles"}, 32'(oe_lo - o0),
          (!we && !eerr) ? 32'(W + 1) : 32'd0);
  endtask

  task automatic model(input logic we, input logic [5:0] a,
                       input logic [31:0] wd, input logic err);
    if (err) return;
    if (we) shadow[a] = wd;
    else last_rd = shadow[a];
  endtask

  vec_t tbl[10];

  initial begin
    int acc[3];
    int e0, b, o0, w0;
    bit ok;
    logic we;
    logic [5:0] a;
    logic [31:0] wd, erd;

    tbl[0] = '{1'b1, 6'd5,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 6'd5,  32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 6'd10, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b0, 6'd10, 32'h0,         32'hA5A5_5A5A, 1'b0};
    tbl[4] = '{1'b0, 6'd5,  32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{1'b1, 6'd47, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    tbl[6] = '{1'b0, 6'd47, 32'h0,         32'hCAFE_F00D, 1'b0};
`ifdef SRAM_CTRL_RANGE_CHK_EN
    tbl[7] = '{1'b1, 6'd50, 32'h1122_3344, 32'hCAFE_F00D, 1'b1};
    tbl[8] = '{1'b0, 6'd50, 32'h0,         32'hCAFE_F00D, 1'b1};
`else
    tbl[7] = '{1'b1, 6'd50, 32'h1122_3344, 32'hCAFE_F00D, 1'b0};
    tbl[8] = '{1'b0, 6'd50, 32'h0,         32'h1122_3344, 1'b0};
`endif
    tbl[9] = '{1'b0, 6'd47, 32'h0,         32'hCAFE_F00D, 1'b0};

    for (int i = 0; i < 64; i++) shadow[i] = '0;
    last_rd = '0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = '0; req_wdata0 = '0;
    preload = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_strobes", 32'({mem_cs_n, mem_we_n, mem_oe_n}), 32'd7);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_req(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err,
              $sformatf("vec%0d", i));
      model(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].err);
    end

    // back-to-back writes with req_valid held high
    b = rsp_cnt;
    req_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req_we    = 1'b1;
      req_addr  = 6'(n);
      req_wdata = 32'hB0B0_0000 + 32'(n);
      accept(ok, e0);
      acc[n] = e0;
      check("b2b_accept", 32'(ok), 32'd1);
      sb.push_back('{rd: last_rd, err: 1'b0, cyc: e0 + W + 3});
      model(1'b1, 6'(n), 32'hB0B0_0000 + 32'(n), 1'b0);
    end
    req_valid = 1'b0;
    for (int n = 0; n < 3; n++) wait_rsp("b2b");
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'(W + 5));
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'(W + 5));
    repeat (4) @(negedge clk);
    check("b2b_rsp_count", 32'(rsp_cnt - b), 32'd3);
    for (int n = 0; n < 3; n++) begin
      run_req(1'b0, 6'(n), 32'h0, shadow[n], 1'b0, "b2b_rdback");
      model(1'b0, 6'(n), 32'h0, 1'b0);
    end

    // reset during the strobe phase of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7;
    req_wdata = 32'h7777_7777;
    accept(ok, e0);
    req_valid = 1'b0;
    check("rst_wr_accept", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (!mem_we_n) ok = 1;
      else @(negedge clk);
    end
    check("rst_wr_strobe", 32'(ok), 32'd1);
    b = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({mem_cs_n, mem_we_n, mem_oe_n}), 32'd7);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rel_ready", 32'(req_ready), 32'd1);
    check("mid_rst_no_rsp", 32'(rsp_cnt - b), 32'd0);
    last_rd = '0;
    run_req(1'b1, 6'd7, 32'h7070_7070, 32'd0, 1'b0, "post_rst_wr");
    model(1'b1, 6'd7, 32'h7070_7070, 1'b0);

    // zero wait-state read of a preloaded word
    o0 = oe_lo0;
    w0 = we_lo0;
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 6'd63;
    for (int i = 0; i < 40 && !ok; i++) begin end
    ok = 0;
    e0 = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready0) begin
        ok = 1;
        e0 = cyc + 1;
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    check("w0_accept", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid0) ok = 1;
      else @(negedge clk);
    end
    check("w0_rsp_seen", 32'(ok), 32'd1);
    check("w0_latency", 32'(cyc), 32'(e0 + 3));
    check("w0_rdata", rsp_rdata0, 32'h1234_5678);
    check("w0_err", 32'(rsp_err0), 32'd0);
    check("w0_oe_cycles", 32'(oe_lo0 - o0), 32'd1);
    check("w0_we_cycles", 32'(we_lo0 - w0), 32'd0);

    // random traffic against the shadow model
    for (int i = 0; i < 100; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 6'($urandom_range(0, 47));
      wd  = $urandom;
      erd = we ? last_rd : shadow[a];
      run_req(we, a, wd, erd, 1'b0, "rand");
      model(we, a, wd, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("strobe_overlap", 32'(strobe_bad), 32'd0);
    check("no_extra_rsp", 32'(got.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
